// File: rtl/adder_share_arbiter_64bit.sv
// Purpose: time-shares one external 64-bit ripple-carry adder among NUM_REQ
//          requesters using a round-robin grant, holds the operands stable for
//          SETTLE_CYCLES so the carry chain settles, then returns a registered
//          sum, carry-out and requester ID on a single response channel.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  per-requester operand-valid
//   req_ready  one-hot grant, combinational from req_valid while idle
//   req_a      operand A, requester i at [64*i+63:64*i]
//   req_b      operand B, same packing
//   add_a      operand A driven to the shared adder (held until next accept)
//   add_b      operand B driven to the shared adder (held until next accept)
//   add_sum    sum from the shared adder
//   add_cout   carry-out from the shared adder
//   rsp_valid  response available
//   rsp_ready  consumer accepts the response
//   rsp_sum    registered sum
//   rsp_cout   registered carry-out
//   rsp_id     index of the requester served
//   busy       high whenever a request is in flight
module adder_share_arbiter_64bit #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_a,
    input  logic [64*NUM_REQ-1:0]   req_b,
    output logic [63:0]             add_a,
    output logic [63:0]             add_b,
    input  logic [63:0]             add_sum,
    input  logic                    add_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [63:0]             rsp_sum,
    output logic                    rsp_cout,
    output logic [2:0]              rsp_id,
    output logic                    busy
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   cnt;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   scan_idx;

    // Round-robin search: first valid requester starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Grant is only offered while idle and out of reset.
    assign req_ready = (state == ST_IDLE && !reset && grant_found)
                       ? (NUM_REQ'(1) << grant_idx) : '0;

    // Arbitration / settle / response sequencing with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        add_a  <= req_a[DATA_W*32'(grant_idx) +: DATA_W];
                        add_b  <= req_b[DATA_W*32'(grant_idx) +: DATA_W];
                        rsp_id <= ID_W'(grant_idx);
                        rr_ptr <= PTR_W'((32'(grant_idx) + 1) % NUM_REQ);
                        cnt    <= CNT_W'(SETTLE_CYCLES);
                        busy   <= 1'b1;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt - CNT_W'(1);
                    // Last settle cycle: the carry chain has resolved.
                    if (cnt == CNT_W'(1)) begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
